// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory side of the core.
//   DM_*        : DMCtrl access-size encodings understood by the data memory
//   sb_entry_t  : one posted store {addr, data, ctrl}
//   Helpers     : store-side ctrl normalisation and alignment check
package riscv_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  ctrl;
  } sb_entry_t;

  // Sign/zero extension only matters for loads, so unsigned store sizes
  // collapse onto their signed counterparts.
  function automatic logic [2:0] store_ctrl_norm(input logic [2:0] ctrl);
    return {1'b0, ctrl[1:0]};
  endfunction

  // Byte never faults, half needs addr[0]=0, anything wider needs addr[1:0]=0.
  function automatic logic store_aligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
    logic ok;
    case (ctrl[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr_lo[0];
      default: ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core/memory bus bundle around the store buffer.
//   Store channel : st_valid, st_ready, st_addr, st_data, st_ctrl
//   Load channel  : ld_req, ld_addr, ld_ctrl, ld_stall
//   Memory port   : mem_addr, mem_data, mem_ctrl, mem_wr
// slave  = the store buffer; master = the core/memory side driving it.
interface store_buffer_if;

  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_ctrl;

  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_ctrl;
  logic        ld_stall;

  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [2:0]  mem_ctrl;
  logic        mem_wr;

  modport slave (
    input  st_valid, st_addr, st_data, st_ctrl,
    input  ld_req, ld_addr, ld_ctrl,
    output st_ready, ld_stall,
    output mem_addr, mem_data, mem_ctrl, mem_wr
  );

  modport master (
    output st_valid, st_addr, st_data, st_ctrl,
    output ld_req, ld_addr, ld_ctrl,
    input  st_ready, ld_stall,
    input  mem_addr, mem_data, mem_ctrl, mem_wr
  );

endinterface

// File: rtl/sync_fifo.sv
// In-order FIFO of sb_entry_t with every slot visible for address compares.
//   clk, rst_n   : clock, async active-low reset (clears pointers/count/valids)
//   push/push_entry : enqueue at wr_ptr (caller guarantees !full)
//   pop          : dequeue head (caller guarantees !empty)
//   head         : entry at rd_ptr
//   entries      : all storage slots; entry_valid marks the live ones
//   count/full/empty : occupancy, count is 0..DEPTH
module sync_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  sb_entry_t                   push_entry,
  input  logic                        pop,
  output sb_entry_t                   head,
  output sb_entry_t [DEPTH-1:0]       entries,
  output logic      [DEPTH-1:0]       entry_valid,
  output logic      [CW-1:0]          count,
  output logic                        full,
  output logic                        empty
);

  logic      [PW-1:0]    wr_ptr;
  logic      [PW-1:0]    rd_ptr;
  logic      [CW-1:0]    count_q;
  logic      [DEPTH-1:0] valid_q;
  sb_entry_t [DEPTH-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // Clear before set: a push may legally land in the slot just popped.
      if (pop) begin
        rd_ptr          <= rd_ptr + PW'(1);
        valid_q[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr          <= wr_ptr + PW'(1);
        valid_q[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload is don't-care until its valid bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= push_entry;
    end
  end

  assign head        = mem_q[rd_ptr];
  assign entries     = mem_q;
  assign entry_valid = valid_q;
  assign count       = count_q;
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core load/store path and data memory.
//   clk, rst_n        : clock, async active-low reset (drops all pending stores)
//   sb (slave)        : store channel in, load channel in, memory port out
//   empty             : no pending stores
//   count             : number of pending stores, 0..DEPTH
//   store_misaligned  : one-cycle pulse after a misaligned store is rejected
// Loads own the shared memory port unless they hit a pending store's word,
// in which case the buffer keeps draining and stalls the load until the
// last matching entry has been written.
module store_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  store_buffer_if.slave          sb,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   store_misaligned
);

  sb_entry_t             head;
  sb_entry_t [DEPTH-1:0] entries;
  sb_entry_t             st_entry;
  logic      [DEPTH-1:0] entry_valid;
  logic                  full;
  logic                  fifo_empty;
  logic                  st_ok;
  logic                  push;
  logic                  pop;
  logic                  hit_any;
  logic                  hit;
  logic                  misaligned_q;

  logic [31:0] mem_addr_c;
  logic [31:0] mem_data_c;
  logic [2:0]  mem_ctrl_c;
  logic        mem_wr_c;
  logic        ld_stall_c;

  // st_ready comes only from occupancy, never from st_valid; a full buffer
  // refuses even when a pop happens the same cycle.
  assign sb.st_ready = ~full;

  assign st_ok    = store_aligned(sb.st_ctrl, sb.st_addr[1:0]);
  assign push     = sb.st_valid & ~full & st_ok;
  assign st_entry = '{addr: sb.st_addr, data: sb.st_data, ctrl: store_ctrl_norm(sb.st_ctrl)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= sb.st_valid & ~full & ~st_ok;
    end
  end

  // Word-granular hazard check against every live entry.
  always_comb begin
    hit_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entries[i].addr[31:2] == sb.ld_addr[31:2])) begin
        hit_any = 1'b1;
      end
    end
  end

  assign hit = sb.ld_req & hit_any;

  always_comb begin
    mem_addr_c = '0;
    mem_data_c = '0;
    mem_ctrl_c = DM_W;
    mem_wr_c   = 1'b0;
    ld_stall_c = 1'b0;
    if (sb.ld_req && !hit) begin
      mem_addr_c = sb.ld_addr;
      mem_ctrl_c = sb.ld_ctrl;
    end else if (!fifo_empty) begin
      // A hitting load implies a non-empty buffer, so it always lands here.
      mem_addr_c = head.addr;
      mem_data_c = head.data;
      mem_ctrl_c = head.ctrl;
      mem_wr_c   = 1'b1;
      ld_stall_c = hit;
    end
  end

  // The memory commits on the same edge the entry leaves the buffer.
  assign pop = mem_wr_c;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (st_entry),
    .pop         (pop),
    .head        (head),
    .entries     (entries),
    .entry_valid (entry_valid),
    .count       (count),
    .full        (full),
    .empty       (fifo_empty)
  );

  assign sb.mem_addr     = mem_addr_c;
  assign sb.mem_data     = mem_data_c;
  assign sb.mem_ctrl     = mem_ctrl_c;
  assign sb.mem_wr       = mem_wr_c;
  assign sb.ld_stall     = ld_stall_c;
  assign empty           = fifo_empty;
  assign store_misaligned = misaligned_q;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import riscv_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic empty;
  logic [$clog2(DEPTH):0] count;
  logic store_misaligned;

  always #5 clk = ~clk;

  store_buffer_if sb_if ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sb               (sb_if),
    .empty            (empty),
    .count            (count),
    .store_misaligned (store_misaligned)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [2:0] sc, input logic lr, input logic [31:0] la,
                       input logic [2:0] lc);
    sb_if.st_valid = sv;
    sb_if.st_addr  = sa;
    sb_if.st_data  = sd;
    sb_if.st_ctrl  = sc;
    sb_if.ld_req   = lr;
    sb_if.ld_addr  = la;
    sb_if.ld_ctrl  = lc;
  endtask

  typedef struct {
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_ctrl;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_ctrl;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [2:0]  exp_ctrl;
    logic        exp_stall;
    logic [3:0]  exp_count;
    logic        exp_mis;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                              input logic [2:0] sc, input logic lr, input logic [31:0] la,
                              input logic [2:0] lc, input logic ew, input logic [31:0] ea,
                              input logic [31:0] ed, input logic [2:0] ec, input logic es,
                              input logic [3:0] en, input logic em);
    vec_t v;
    v.st_valid = sv; v.st_addr = sa; v.st_data = sd; v.st_ctrl = sc;
    v.ld_req = lr; v.ld_addr = la; v.ld_ctrl = lc;
    v.exp_wr = ew; v.exp_addr = ea; v.exp_data = ed; v.exp_ctrl = ec;
    v.exp_stall = es; v.exp_count = en; v.exp_mis = em;
    return v;
  endfunction

  // Reference model: pending stores as a plain queue.
  sb_entry_t q[$];
  logic      model_mis;

  function automatic int size_bytes(input logic [2:0] c);
    if (c == DM_B || c == DM_BU) return 1;
    if (c == DM_H || c == DM_HU) return 2;
    return 4;
  endfunction

  function automatic logic [2:0] size_ctrl(input int nbytes);
    if (nbytes == 1) return DM_B;
    if (nbytes == 2) return DM_H;
    return DM_W;
  endfunction

  vec_t vt[13];
  logic [2:0] ctrl_pool[5];

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 32'h40, 32'h1111_2222, DM_W, 1'b0, 32'h0, DM_W);

    // ---------------- reset with a store presented ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.empty", 32'(empty), 32'd1);
    chk("reset.st_ready", 32'(sb_if.st_ready), 32'd1);
    chk("reset.mem_wr", 32'(sb_if.mem_wr), 32'd0);
    chk("reset.ld_stall", 32'(sb_if.ld_stall), 32'd0);
    chk("reset.misaligned", 32'(store_misaligned), 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, DM_W, 1'b0, 32'h0, DM_W);
    rst_n = 1'b1;

    // ---------------- table-driven sequence ----------------
    //           st_v addr        data          ctrl   ld  ld_addr  ld_ctrl  wr addr         data          ctrl  stl cnt mis
    vt[0]  = mk(1, 32'h10, 32'hDEAD_BEEF, DM_W,  0, 32'h0,  DM_W,    0, 32'h0,       32'h0,         DM_W, 0, 0, 0);
    vt[1]  = mk(0, 32'h0,  32'h0,         DM_W,  0, 32'h0,  DM_W,    1, 32'h10,      32'hDEAD_BEEF, DM_W, 0, 1, 0);
    vt[2]  = mk(0, 32'h0,  32'h0,         DM_W,  0, 32'h0,  DM_W,    0, 32'h0,       32'h0,         DM_W, 0, 0, 0);
    vt[3]  = mk(1, 32'h21, 32'hAA,        DM_B,  1, 32'h80, DM_W,    0, 32'h80,      32'h0,         DM_W, 0, 0, 0);
    vt[4]  = mk(0, 32'h0,  32'h0,         DM_W,  1, 32'h20, DM_W,    1, 32'h21,      32'hAA,        DM_B, 1, 1, 0);
    vt[5]  = mk(0, 32'h0,  32'h0,         DM_W,  1, 32'h20, DM_W,    0, 32'h20,      32'h0,         DM_W, 0, 0, 0);
    vt[6]  = mk(1, 32'h13, 32'h55,        DM_H,  0, 32'h0,  DM_W,    0, 32'h0,       32'h0,         DM_W, 0, 0, 0);
    vt[7]  = mk(1, 32'h12, 32'h66,        DM_W,  0, 32'h0,  DM_W,    0, 32'h0,       32'h0,         DM_W, 0, 0, 1);
    vt[8]  = mk(0, 32'h0,  32'h0,         DM_W,  0, 32'h0,  DM_W,    0, 32'h0,       32'h0,         DM_W, 0, 0, 1);
    vt[9]  = mk(0, 32'h0,  32'h0,         DM_W,  0, 32'h0,  DM_W,    0, 32'h0,       32'h0,         DM_W, 0, 0, 0);
    vt[10] = mk(1, 32'h33, 32'h1234_5655, DM_BU, 0, 32'h0,  DM_W,    0, 32'h0,       32'h0,         DM_W, 0, 0, 0);
    vt[11] = mk(0, 32'h0,  32'h0,         DM_W,  0, 32'h0,  DM_W,    1, 32'h33,      32'h1234_5655, DM_B, 0, 1, 0);
    vt[12] = mk(0, 32'h0,  32'h0,         DM_W,  0, 32'h0,  DM_W,    0, 32'h0,       32'h0,         DM_W, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vt[i].st_valid, vt[i].st_addr, vt[i].st_data, vt[i].st_ctrl,
            vt[i].ld_req, vt[i].ld_addr, vt[i].ld_ctrl);
      #1;
      chk($sformatf("vec%0d.mem_wr", i), 32'(sb_if.mem_wr), 32'(vt[i].exp_wr));
      chk($sformatf("vec%0d.mem_addr", i), sb_if.mem_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d.mem_ctrl", i), 32'(sb_if.mem_ctrl), 32'(vt[i].exp_ctrl));
      if (!(vt[i].ld_req && !vt[i].exp_wr))
        chk($sformatf("vec%0d.mem_data", i), sb_if.mem_data, vt[i].exp_data);
      chk($sformatf("vec%0d.ld_stall", i), 32'(sb_if.ld_stall), 32'(vt[i].exp_stall));
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vt[i].exp_count));
      chk($sformatf("vec%0d.misaligned", i), 32'(store_misaligned), 32'(vt[i].exp_mis));
    end

    // ---------------- fill behind a load, then drain ----------------
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 32'(4 * i), 32'h1000 + 32'(i), DM_W, 1'b1, 32'h80, DM_W);
      #1;
      chk($sformatf("fill%0d.count", i), 32'(count), 32'(i));
      chk($sformatf("fill%0d.st_ready", i), 32'(sb_if.st_ready), 32'd1);
      chk($sformatf("fill%0d.mem_wr", i), 32'(sb_if.mem_wr), 32'd0);
    end
    @(negedge clk);
    drive(1'b1, 32'h40, 32'h9999, DM_W, 1'b1, 32'h80, DM_W);
    #1;
    chk("full.count", 32'(count), 32'd4);
    chk("full.st_ready", 32'(sb_if.st_ready), 32'd0);
    chk("full.mem_wr", 32'(sb_if.mem_wr), 32'd0);
    chk("full.mem_addr", sb_if.mem_addr, 32'h80);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, DM_W, 1'b0, 32'h0, DM_W);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain%0d.mem_wr", i), 32'(sb_if.mem_wr), 32'd1);
      chk($sformatf("drain%0d.mem_addr", i), sb_if.mem_addr, 32'(4 * i));
      chk($sformatf("drain%0d.mem_data", i), sb_if.mem_data, 32'h1000 + 32'(i));
      chk($sformatf("drain%0d.count", i), 32'(count), 32'(4 - i));
      @(negedge clk);
    end
    #1;
    chk("drained.empty", 32'(empty), 32'd1);
    chk("drained.mem_wr", 32'(sb_if.mem_wr), 32'd0);

    // ---------------- asynchronous reset mid-drain ----------------
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h200 + 32'(4 * i), 32'h77 + 32'(i), DM_W, 1'b1, 32'h80, DM_W);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, DM_W, 1'b1, 32'h80, DM_W);
    #1;
    chk("prerst.count", 32'(count), 32'd3);
    sb_if.ld_req = 1'b0;
    #1;
    chk("prerst.mem_wr", 32'(sb_if.mem_wr), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.empty", 32'(empty), 32'd1);
    chk("midrst.mem_wr", 32'(sb_if.mem_wr), 32'd0);
    chk("midrst.st_ready", 32'(sb_if.st_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("postrst%0d.mem_wr", i), 32'(sb_if.mem_wr), 32'd0);
      @(negedge clk);
    end

    // ---------------- randomized against the queue model ----------------
    ctrl_pool[0] = DM_B; ctrl_pool[1] = DM_H; ctrl_pool[2] = DM_W;
    ctrl_pool[3] = DM_BU; ctrl_pool[4] = DM_HU;
    q.delete();
    model_mis = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        sv, lr, hit, ew, es, ready, ok;
      logic [31:0] sa, sd, la, ea, ed;
      logic [2:0]  sc, lc, ec;
      sb_entry_t   e;
      int          nb;
      if (cyc != 0) @(negedge clk);
      sv = ($urandom_range(0, 9) < 6);
      sa = 32'h100 + ($urandom & 32'h1F);
      sd = $urandom;
      sc = ctrl_pool[$urandom_range(0, 4)];
      lr = ($urandom_range(0, 9) < 4);
      la = 32'h100 + ($urandom & 32'h1F);
      lc = ctrl_pool[$urandom_range(0, 4)];
      drive(sv, sa, sd, sc, lr, la, lc);
      #1;
      ready = (q.size() < DEPTH);
      hit = 1'b0;
      foreach (q[k]) if ((q[k].addr / 4) == (la / 4)) hit = 1'b1;
      hit = hit && lr;
      ew = 1'b0; es = 1'b0; ea = 32'h0; ed = 32'h0; ec = DM_W;
      if (lr && !hit) begin
        ea = la; ec = lc;
      end else if (q.size() > 0) begin
        ew = 1'b1; es = hit; ea = q[0].addr; ed = q[0].data; ec = q[0].ctrl;
      end
      chk("rnd.mem_wr", 32'(sb_if.mem_wr), 32'(ew));
      chk("rnd.mem_addr", sb_if.mem_addr, ea);
      chk("rnd.mem_ctrl", 32'(sb_if.mem_ctrl), 32'(ec));
      if (!(lr && !ew)) chk("rnd.mem_data", sb_if.mem_data, ed);
      chk("rnd.ld_stall", 32'(sb_if.ld_stall), 32'(es));
      chk("rnd.count", 32'(count), 32'(q.size()));
      chk("rnd.empty", 32'(empty), 32'(q.size() == 0));
      chk("rnd.st_ready", 32'(sb_if.st_ready), 32'(ready));
      chk("rnd.misaligned", 32'(store_misaligned), 32'(model_mis));
      nb = size_bytes(sc);
      ok = ((sa % nb) == 0);
      model_mis = sv && ready && !ok;
      if (ew) void'(q.pop_front());
      if (sv && ready && ok) begin
        e.addr = sa; e.data = sd; e.ctrl = size_ctrl(nb);
        q.push_back(e);
      end
    end

    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, DM_W, 1'b0, 32'h0, DM_W);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
